// File: rtl/vliw_pkg.sv
// Shared types and constants for the 2-slot VLIW operand-fetch stage.
package vliw_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned NREG  = 16;
    localparam int unsigned AW    = $clog2(NREG);
    localparam int unsigned NSLOT = 2;

    localparam logic [DW-1:0] REG_RST = 16'h00FF;

    typedef logic [DW-1:0] data_t;
    typedef logic [AW-1:0] addr_t;

    typedef struct packed {
        data_t [NSLOT-1:0] opa;
        data_t [NSLOT-1:0] opb;
        addr_t [NSLOT-1:0] dst;
        logic  [NSLOT-1:0] wr;
    } bundle_t;

    function automatic logic [NREG-1:0] addr_mask(input logic en, input addr_t a);
        logic [NREG-1:0] mask;
        mask = '0;
        if (en) begin
            mask[a] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Busy-bit scoreboard for in-flight destinations; eff_busy_o already hides
// registers whose writeback lands this cycle.
module operand_fetch_scoreboard
    import vliw_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic  [NSLOT-1:0]   set_en_i,
    input  addr_t [NSLOT-1:0]   set_addr_i,
    input  logic  [NSLOT-1:0]   clr_en_i,
    input  addr_t [NSLOT-1:0]   clr_addr_i,
    output logic  [NREG-1:0]    eff_busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int s = 0; s < NSLOT; s++) begin
            set_mask |= addr_mask(set_en_i[s], set_addr_i[s]);
            clr_mask |= addr_mask(clr_en_i[s], clr_addr_i[s]);
        end
        // Set applied after clear so a new writer wins over a retiring one.
        busy_d     = (busy_q & ~clr_mask) | set_mask;
        eff_busy_o = busy_q & ~clr_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file, writeback bypass, hazard stall and a
// one-entry output register toward execute.
module operand_fetch
    import vliw_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  addr_t [NSLOT-1:0]   in_src_a,
    input  addr_t [NSLOT-1:0]   in_src_b,
    input  addr_t [NSLOT-1:0]   in_dst,
    input  logic  [NSLOT-1:0]   in_wr,
    input  logic  [NSLOT-1:0]   wb_en,
    input  addr_t [NSLOT-1:0]   wb_addr,
    input  data_t [NSLOT-1:0]   wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output data_t [NSLOT-1:0]   out_opa,
    output data_t [NSLOT-1:0]   out_opb,
    output addr_t [NSLOT-1:0]   out_dst,
    output logic  [NSLOT-1:0]   out_wr
);

    data_t           regs_q [NREG];
    data_t           regs_d [NREG];
    bundle_t         out_q;
    bundle_t         out_d;
    logic            out_valid_q;
    logic            out_valid_d;
    logic [NREG-1:0] eff_busy;
    logic            hazard;
    logic            accept;
    bundle_t         fetched;

    operand_fetch_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (in_wr & {NSLOT{accept}}),
        .set_addr_i (in_dst),
        .clr_en_i   (wb_en),
        .clr_addr_i (wb_addr),
        .eff_busy_o (eff_busy)
    );

    // Sources are checked whether or not the slot uses them.
    always_comb begin
        hazard = 1'b0;
        for (int s = 0; s < NSLOT; s++) begin
            hazard |= eff_busy[in_src_a[s]] | eff_busy[in_src_b[s]]
                    | (in_wr[s] & eff_busy[in_dst[s]]);
        end
        in_ready = !hazard && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    // Register read with same-cycle writeback bypass; higher slot wins.
    always_comb begin
        fetched = '0;
        for (int s = 0; s < NSLOT; s++) begin
            fetched.opa[s] = regs_q[in_src_a[s]];
            fetched.opb[s] = regs_q[in_src_b[s]];
            for (int w = 0; w < NSLOT; w++) begin
                if (wb_en[w] && (wb_addr[w] == in_src_a[s])) begin
                    fetched.opa[s] = wb_data[w];
                end
                if (wb_en[w] && (wb_addr[w] == in_src_b[s])) begin
                    fetched.opb[s] = wb_data[w];
                end
            end
        end
        fetched.dst = in_dst;
        fetched.wr  = in_wr;
    end

    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NSLOT; w++) begin
            if (wb_en[w]) begin
                regs_d[wb_addr[w]] = wb_data[w];
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_d       = fetched;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= REG_RST;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_opa   = out_q.opa;
    assign out_opb   = out_q.opb;
    assign out_dst   = out_q.dst;
    assign out_wr    = out_q.wr;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage of the 2-slot VLIW pipeline: holds the architectural register file, reads two source operands per slot for each decoded bundle, and presents them to execute through a one-entry output register. A busy-bit scoreboard tracks in-flight destinations and stalls any bundle with a RAW or WAW hazard. Same-cycle writebacks are bypassed into the fetched operands. Sits between decode (upstream valid/ready) and execute (downstream valid/ready); writebacks arrive from the end of execute.

## Interface
- DW, 16, data width
- NREG, 16, number of architectural registers
- AW, $clog2(NREG), register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  decoded bundle present
- in_ready  out  1  bundle accepted this cycle when in_valid && in_ready
- in_src_a[s], in_src_b[s]  in  AW each, s=0..1  source addresses
- in_dst[s]  in  AW  destination address
- in_wr[s]  in  1  slot s writes in_dst[s]
- wb_en[s]  in  1  writeback from slot s this cycle
- wb_addr[s]  in  AW  writeback address
- wb_data[s]  in  DW  writeback data
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute accepts bundle
- out_opa[s], out_opb[s]  out  DW  fetched operands
- out_dst[s]  out  AW, out_wr[s]  out  1  forwarded destination info

## Operation
- Register file: NREG x DW flops, all reset to 16'h00FF. No hard-wired zero register.
- Writeback: regs[wb_addr[s]] <= wb_data[s] when wb_en[s]. If both slots target the same address, slot 1 wins.
- Scoreboard: one busy bit per register, all clear at reset.
  - On accept, busy[in_dst[s]] is set for each slot with in_wr[s].
  - busy[wb_addr[s]] is cleared on wb_en[s].
  - If set and clear hit the same register in the same cycle, set wins.
- Effective busy: eff_busy[r] = busy[r] && !(wb_en[0] && wb_addr[0]==r) && !(wb_en[1] && wb_addr[1]==r).
- Hazard: the bundle stalls if any of the following holds.
  - Any source of either slot has eff_busy set (RAW). Sources are checked regardless of use.
  - Any in_wr[s] destination has eff_busy set (WAW).
- in_ready = !hazard && (!out_valid || out_ready).
- Operand read and bypass: each operand takes wb_data from a matching same-cycle writeback (slot 1 priority), else the register value.
- Intra-bundle semantics:
  - Both slots read pre-bundle values; slot 1 never sees slot 0's result.
  - If both slots write the same dst, the bundle is accepted, the busy bit is set once, and the later writebacks resolve it.
- Output register:
  - Loaded on accept.
  - out_valid is set on accept and cleared when out_ready && !accept.
  - Holds stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0; out_opa, out_opb = 0; out_dst=0; out_wr=0; all regs 16'h00FF; busy all 0.
- Latency: accept in cycle N gives out_valid with data in cycle N+1. Throughput is one bundle per cycle when hazard-free.
- Writeback in cycle N is visible to a bundle accepted in cycle N through the bypass, and through the register file from N+1.
- in_ready depends combinationally on in_* addresses, wb_*, and out_ready. Decode must not make in_valid depend on in_ready.
- Reset mid-operation: all state returns to its reset values immediately, and any pending bundle or busy bit is discarded.

## Structure
- Shared package vliw_pkg holds DW, NREG, AW, NSLOT=2, and the register reset constant REG_RST=16'h00FF.
- One natural sub-module, scoreboard: busy bits, set/clear ports, and the eff_busy output. The register file, bypass, and output register stay in operand_fetch.

## Test plan
- Reset, then read r3 via slot 0 src_a -> out_opa[0]=16'h00FF one cycle after accept; out_valid=0 during reset.
- Bundle writes r5 (in_wr[0]=1), next bundle reads r5 -> in_ready=0 until wb_en[0], wb_addr=5, wb_data=16'h1234; in that cycle accept with out_opa=16'h1234 next cycle.
- Both wb slots write r2 (16'hAAAA slot 0, 16'hBBBB slot 1) same cycle -> subsequent read of r2 returns 16'hBBBB.
- out_ready=0 with out_valid=1 -> in_ready=0, outputs stable; raise out_ready with new bundle -> back-to-back transfer, no bubble.
- WAW: r7 busy, bundle with in_wr[1]=1, in_dst[1]=7 -> stalled until r7 writeback. Same-cycle clear+set on r7 leaves busy[7]=1.
- Assert rst with busy bits set and out_valid=1 -> out_valid=0, busy clear, and reading r7 gives 16'h00FF.
